axi_read_responder: RTL and testbench

AXI-style read responder (slave) for the mips_core memory side. It serves burst refill requests from cache read masters: it accepts requests on the read-address channel and returns line data beat-by-beat on the read-data channel. Data is fetched from an external word-addressed synchronous-read backing store. The block provides programmable initial latency, a small request queue and full-throughput bursts under RREADY backpressure.

---
 rtl/axi_resp_pkg.sv | 38 +++
 rtl/axi_read_responder_req_fifo.sv | 74 +++++++
 rtl/axi_read_responder.sv | 152 +++++++++++++++
 tb/tb_axi_read_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_resp_pkg.sv
// Shared types and constants for the AXI read responder.
package axi_resp_pkg;

  localparam int ADDR_WIDTH_DEF = 26;
  localparam int WORD_WIDTH     = ADDR_WIDTH_DEF - 2;
  localparam int MAX_BURST_DEF  = 16;
  localparam int LEN_WIDTH      = $clog2(MAX_BURST_DEF + 1);
  localparam int ID_WIDTH       = 4;
  localparam int AXLEN_WIDTH    = 8;

  // One queued read request: start word address, beat count and transaction id.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [ID_WIDTH-1:0]   id;
  } rd_req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } engine_state_t;

  // ARLEN is a beat count; zero means one beat and anything above max_burst is clamped.
  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [AXLEN_WIDTH-1:0] raw,
                                                     input int max_burst);
    logic [LEN_WIDTH-1:0] result;
    if (raw == '0) begin
      result = LEN_WIDTH'(1);
    end else if (int'(raw) > max_burst) begin
      result = LEN_WIDTH'(max_burst);
    end else begin
      result = raw[LEN_WIDTH-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_read_responder_req_fifo.sv
// Small request queue with registered full/empty flags and same-cycle push/pop.
module req_fifo
  import axi_resp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  rd_req_t push_data,
  input  logic    pop,
  output rd_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  rd_req_t              entries [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 do_push;
  logic                 do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = entries[rd_ptr];

  // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_ONE;
    end
  end

  // Entry storage needs no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap at DEPTH; flags are registered from the next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI-style read responder: queues burst requests and streams words from a synchronous backing store.
module axi_read_responder
  import axi_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = 32,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 2,
  parameter int MAX_BURST   = MAX_BURST_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ar_valid,
  output logic                   ar_ready,
  input  logic [ADDR_WIDTH-1:0]  ar_addr,
  input  logic [AXLEN_WIDTH-1:0] ar_len,
  input  logic [ID_WIDTH-1:0]    ar_id,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [DATA_WIDTH-1:0]  r_data,
  output logic                   r_last,
  output logic [ID_WIDTH-1:0]    r_id,
  output logic [ADDR_WIDTH-3:0]  o_mem_raddr,
  input  logic [DATA_WIDTH-1:0]  i_mem_rdata
);

  localparam int CNT_WIDTH = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_WIDTH-1:0]    CNT_LOAD = CNT_WIDTH'(LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-3:0]   ADDR_ONE = (ADDR_WIDTH-2)'(1);
  localparam logic [LEN_WIDTH-1:0]    LEN_ONE  = LEN_WIDTH'(1);

  rd_req_t               push_req;
  rd_req_t               head_req;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  last_beat;
  logic                  unused_addr_lsb;

  engine_state_t         state;
  engine_state_t         state_next;
  logic [ADDR_WIDTH-3:0] cur_addr;
  logic [ADDR_WIDTH-3:0] cur_addr_next;
  logic [LEN_WIDTH-1:0]  beats_left;
  logic [LEN_WIDTH-1:0]  beats_left_next;
  logic [ID_WIDTH-1:0]   cur_id;
  logic [ID_WIDTH-1:0]   cur_id_next;
  logic [CNT_WIDTH-1:0]  wait_cnt;
  logic [CNT_WIDTH-1:0]  wait_cnt_next;

  // ARREADY is held low while reset is asserted, otherwise it follows the registered full flag.
  assign ar_ready        = rst_n & ~fifo_full;
  assign push            = ar_valid & ar_ready;
  assign unused_addr_lsb = ^ar_addr[1:0];

  // Byte offset bits are dropped; the length is normalised before it is queued.
  always_comb begin
    push_req      = '0;
    push_req.addr = ar_addr[ADDR_WIDTH-1:2];
    push_req.len  = clamp_len(ar_len, MAX_BURST);
    push_req.id   = ar_id;
  end

  req_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_req),
    .pop      (pop),
    .pop_data (head_req),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign r_data = i_mem_rdata;
  assign r_id   = cur_id;

  // Engine next-state, read-channel outputs and the one-cycle-ahead memory address.
  always_comb begin
    state_next      = state;
    cur_addr_next   = cur_addr;
    beats_left_next = beats_left;
    cur_id_next     = cur_id;
    wait_cnt_next   = wait_cnt;
    pop             = 1'b0;
    r_valid         = 1'b0;
    r_last          = 1'b0;
    last_beat       = (beats_left == LEN_ONE);
    o_mem_raddr     = cur_addr;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop             = 1'b1;
          cur_addr_next   = head_req.addr;
          beats_left_next = head_req.len;
          cur_id_next     = head_req.id;
          wait_cnt_next   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_next  = BURST;
            o_mem_raddr = head_req.addr;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        wait_cnt_next = wait_cnt - CNT_ONE;
        if (wait_cnt == CNT_ONE) begin
          state_next = BURST;
        end
      end
      BURST: begin
        r_valid = 1'b1;
        r_last  = last_beat;
        if (r_ready) begin
          if (last_beat) begin
            state_next = IDLE;
          end else begin
            cur_addr_next   = cur_addr + ADDR_ONE;
            beats_left_next = beats_left - LEN_ONE;
            o_mem_raddr     = cur_addr + ADDR_ONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Engine state register; reset drops any in-flight burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      cur_id     <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_next;
      cur_addr   <= cur_addr_next;
      beats_left <= beats_left_next;
      cur_id     <= cur_id_next;
      wait_cnt   <= wait_cnt_next;
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed self-checking bench for axi_read_responder (LATENCY=4, QUEUE_DEPTH=2).
module tb_axi_read_responder;

  logic        clk;
  logic        rst_n;
  logic        ar_valid;
  logic        ar_ready;
  logic [25:0] ar_addr;
  logic [7:0]  ar_len;
  logic [3:0]  ar_id;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_last;
  logic [3:0]  r_id;
  logic [23:0] o_mem_raddr;
  logic [31:0] mem_rdata;

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;

  logic [31:0] beatData[$];
  logic        beatLast[$];
  logic [3:0]  beatId[$];
  int          beatCycle[$];

  axi_read_responder #(
    .ADDR_WIDTH (26),
    .DATA_WIDTH (32),
    .LATENCY    (4),
    .QUEUE_DEPTH(2),
    .MAX_BURST  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ar_valid   (ar_valid),
    .ar_ready   (ar_ready),
    .ar_addr    (ar_addr),
    .ar_len     (ar_len),
    .ar_id      (ar_id),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_data     (r_data),
    .r_last     (r_last),
    .r_id       (r_id),
    .o_mem_raddr(o_mem_raddr),
    .i_mem_rdata(mem_rdata)
  );

  // Backing store contents: word i holds i*16 + 0xA0.
  function automatic logic [31:0] wordVal(input logic [23:0] w);
    return {4'h0, w, 4'h0} + 32'h0000_00A0;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used for latency measurements.
  always @(posedge clk) cycle <= cycle + 1;

  // Synchronous-read backing store model.
  always @(posedge clk) mem_rdata <= wordVal(o_mem_raddr);

  // Record every read-data handshake away from the active edge.
  always @(negedge clk) begin
    if (rst_n && r_valid && r_ready) begin
      beatData.push_back(r_data);
      beatLast.push_back(r_last);
      beatId.push_back(r_id);
      beatCycle.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearBeats();
    beatData.delete();
    beatLast.delete();
    beatId.delete();
    beatCycle.delete();
  endtask

  // Advance to just after the rising edge that starts cycle n.
  task automatic toCycle(input int n);
    while (cycle < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one AR request and return the cycle in which it was accepted (-1 on timeout).
  task automatic applyStimulus(input logic [25:0] addr, input logic [7:0] len,
                               input logic [3:0] id, output int t);
    t = -1;
    if (clk == 1'b0) begin
      @(posedge clk);
      #1;
    end
    ar_addr  = addr;
    ar_len   = len;
    ar_id    = id;
    ar_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ar_ready) begin
        t = cycle;
        break;
      end
    end
    @(posedge clk);
    #1;
    ar_valid = 1'b0;
    if (t < 0) checkOutput("ar_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitBeats(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && beatData.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput(tag, beatData.size(), n);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int t2;
    int t3;
    int lastCount;
    logic [23:0] wrapWords [4];

    rst_n    = 1'b0;
    ar_valid = 1'b0;
    ar_addr  = '0;
    ar_len   = '0;
    ar_id    = '0;
    r_ready  = 1'b1;

    // Reset values
    #12;
    checkOutput("rst_rvalid", r_valid, 0);
    checkOutput("rst_rlast", r_last, 0);
    checkOutput("rst_rid", r_id, 0);
    checkOutput("rst_arready", ar_ready, 0);
    checkOutput("rst_raddr", o_mem_raddr, 0);
    #10 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_arready", ar_ready, 1);

    // Test 1: single 4-beat burst, no backpressure
    clearBeats();
    applyStimulus(26'h000_0100, 8'd4, 4'd3, t);
    waitBeats(4, 40, "t1_beats");
    for (int k = 0; k < 4 && k < beatData.size(); k++) begin
      checkOutput($sformatf("t1_data%0d", k), beatData[k], wordVal(24'h40 + 24'(k)));
      checkOutput($sformatf("t1_last%0d", k), beatLast[k], (k == 3) ? 1 : 0);
      checkOutput($sformatf("t1_id%0d", k), beatId[k], 3);
      checkOutput($sformatf("t1_cycle%0d", k), beatCycle[k] - t, 5 + k);
    end
    repeat (4) @(negedge clk);

    // Test 2: beat 1 stalled for three cycles
    clearBeats();
    applyStimulus(26'h000_0100, 8'd4, 4'd3, t);
    toCycle(t + 6);
    r_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checkOutput($sformatf("t2_stall_valid%0d", s), r_valid, 1);
      checkOutput($sformatf("t2_stall_data%0d", s), r_data, wordVal(24'h41));
      checkOutput($sformatf("t2_stall_last%0d", s), r_last, 0);
      checkOutput($sformatf("t2_stall_id%0d", s), r_id, 3);
    end
    toCycle(t + 9);
    r_ready = 1'b1;
    waitBeats(4, 40, "t2_beats");
    for (int k = 0; k < 4 && k < beatData.size(); k++) begin
      checkOutput($sformatf("t2_data%0d", k), beatData[k], wordVal(24'h40 + 24'(k)));
      checkOutput($sformatf("t2_last%0d", k), beatLast[k], (k == 3) ? 1 : 0);
    end
    if (beatCycle.size() >= 4) begin
      checkOutput("t2_cycle0", beatCycle[0] - t, 5);
      checkOutput("t2_cycle1", beatCycle[1] - t, 9);
      checkOutput("t2_cycle3", beatCycle[3] - t, 11);
    end
    repeat (10) @(negedge clk);
    checkOutput("t2_no_extra", beatData.size(), 4);

    // Test 3: three back-to-back requests through a two-entry queue
    clearBeats();
    applyStimulus(26'h000_0200, 8'd2, 4'd1, t);
    applyStimulus(26'h000_0280, 8'd2, 4'd2, t2);
    applyStimulus(26'h000_0300, 8'd2, 4'd3, t3);
    checkOutput("t3_full_arready", ar_ready, 0);
    checkOutput("t3_accept2", t2 - t, 1);
    checkOutput("t3_accept3", t3 - t, 2);
    waitBeats(6, 80, "t3_beats");
    for (int k = 0; k < 6 && k < beatData.size(); k++) begin
      checkOutput($sformatf("t3_id%0d", k), beatId[k], 1 + k / 2);
      checkOutput($sformatf("t3_last%0d", k), beatLast[k], k % 2);
      checkOutput($sformatf("t3_data%0d", k), beatData[k],
                  wordVal(24'h80 + 24'(32 * (k / 2)) + 24'(k % 2)));
      checkOutput($sformatf("t3_cycle%0d", k), beatCycle[k] - t, 5 + 6 * (k / 2) + (k % 2));
    end
    repeat (4) @(negedge clk);

    // Test 4: word address wraps at the top of the address space
    wrapWords[0] = 24'hFF_FFFE;
    wrapWords[1] = 24'hFF_FFFF;
    wrapWords[2] = 24'h00_0000;
    wrapWords[3] = 24'h00_0001;
    clearBeats();
    applyStimulus(26'h3FF_FFF8, 8'd4, 4'd4, t);
    waitBeats(4, 40, "t4_beats");
    for (int k = 0; k < 4 && k < beatData.size(); k++) begin
      checkOutput($sformatf("t4_data%0d", k), beatData[k], wordVal(wrapWords[k]));
    end
    repeat (4) @(negedge clk);

    // Test 5: asynchronous reset mid-burst with a request queued
    clearBeats();
    applyStimulus(26'h000_0100, 8'd4, 4'd5, t);
    applyStimulus(26'h000_0180, 8'd2, 4'd6, t2);
    toCycle(t + 6);
    checkOutput("t5_pre_valid", r_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_valid", r_valid, 0);
    checkOutput("t5_async_last", r_last, 0);
    checkOutput("t5_async_id", r_id, 0);
    checkOutput("t5_async_arready", ar_ready, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("t5_release_arready", ar_ready, 1);
    clearBeats();
    repeat (20) @(negedge clk);
    checkOutput("t5_no_beats", beatData.size(), 0);
    checkOutput("t5_idle_valid", r_valid, 0);

    // Test 6: ARLEN of 0 gives one beat, ARLEN of 20 clamps to 16
    clearBeats();
    applyStimulus(26'h000_0040, 8'd0, 4'd7, t);
    waitBeats(1, 40, "t6_len0_beats");
    repeat (8) @(negedge clk);
    checkOutput("t6_len0_count", beatData.size(), 1);
    if (beatData.size() >= 1) begin
      checkOutput("t6_len0_last", beatLast[0], 1);
      checkOutput("t6_len0_data", beatData[0], wordVal(24'h10));
      checkOutput("t6_len0_id", beatId[0], 7);
    end
    clearBeats();
    applyStimulus(26'h000_0000, 8'd20, 4'd8, t);
    waitBeats(16, 80, "t6_len20_beats");
    repeat (10) @(negedge clk);
    checkOutput("t6_len20_count", beatData.size(), 16);
    lastCount = 0;
    for (int k = 0; k < beatLast.size(); k++) lastCount += int'(beatLast[k]);
    checkOutput("t6_len20_lastcount", lastCount, 1);
    if (beatData.size() >= 16) begin
      checkOutput("t6_len20_last15", beatLast[15], 1);
      checkOutput("t6_len20_data15", beatData[15], wordVal(24'd15));
      checkOutput("t6_len20_id15", beatId[15], 8);
      checkOutput("t6_len20_cycle15", beatCycle[15] - t, 20);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
